regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, meaning the maximum consecutive ALU grants while a load is pending (range 1..7).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 alu_valid  in  1  ALU result write request.
REQ-005 alu_ready  out  1  ALU request accepted this cycle when alu_valid and alu_ready are both high.
REQ-006 alu_waddr  in  5  ALU destination register.
REQ-007 alu_wdata  in  32  ALU result.
REQ-008 mem_valid  in  1  load-return write request.
REQ-009 mem_ready  out  1  load accepted this cycle when mem_valid and mem_ready are both high.
REQ-010 mem_waddr  in  5  load destination register.
REQ-011 mem_wdata  in  32  load data.
REQ-012 rf_we  out  1  register file write enable; registered.
REQ-013 rf_waddr  out  5  register file write address; registered.
REQ-014 rf_wdata  out  32  register file write data; registered.
REQ-015 load_pending  out  2  current load FIFO occupancy (0..2).

Function
REQ-016 The block SHALL perform at most one register file write per cycle; a request granted at edge N SHALL appear on rf_* during cycle N+1.
REQ-017 The block SHALL hold accepted loads in a 2-entry in-order FIFO and SHALL drive mem_ready = (load_pending < 2), with no dependence on a same-cycle pop.
REQ-018 Grant selection SHALL be as follows:
- if the FIFO is non-empty and (starve_cnt == STARVE_LIMIT or alu_valid = 0), pop the FIFO head;
- otherwise, if alu_valid = 1, grant the ALU;
- otherwise, issue no write.
REQ-019 alu_ready SHALL equal NOT(load_pending != 0 AND starve_cnt == STARVE_LIMIT); it is combinational from state only.
REQ-020 starve_cnt (3 bits, internal) SHALL increment, saturating at STARVE_LIMIT, on every ALU grant while the FIFO is non-empty, and SHALL clear on every FIFO pop or whenever the FIFO is empty.
REQ-021 A granted request with waddr = 0 SHALL complete its handshake and leave the FIFO, and SHALL drive rf_we = 0 in cycle N+1; rf_waddr and rf_wdata still update.
REQ-022 If no request is granted, the block SHALL drive rf_we = 0 in the next cycle and SHALL hold rf_waddr and rf_wdata.
REQ-023 A simultaneous push and pop SHALL be legal at any occupancy below 2, and load_pending SHALL remain unchanged.
REQ-024 Loads SHALL be written in acceptance order; there SHALL be no ordering guarantee between ALU and load writes beyond REQ-018.

Reset
REQ-025 On reset assertion, the block SHALL set rf_we = 0, rf_waddr = 0, rf_wdata = 0, load_pending = 0 and starve_cnt = 0, and SHALL empty the FIFO, discarding its entries.
REQ-026 During reset, the block SHALL drive alu_ready = 1 and mem_ready = 1, but no handshake SHALL take effect.
REQ-027 Reset asserted mid-stream SHALL discard any write in flight; the first grant after deassertion SHALL appear on rf_* no earlier than the second rising edge after deassertion.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL control the load bypass path.
REQ-029 With WB_BYPASS_EN defined: when the FIFO is empty, alu_valid = 0 and mem_valid = 1, the block SHALL grant the load directly (1-cycle latency) without entering the FIFO.
REQ-030 Without WB_BYPASS_EN: every load SHALL enter the FIFO and is eligible no earlier than the cycle after acceptance (minimum 2-cycle latency).
REQ-031 All other requirements SHALL hold unchanged in both builds.

Verification
REQ-032 Single ALU request: alu_valid = 1, waddr = 5, wdata = 0x1234 for one cycle -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234.
REQ-033 Single load with bypass: mem_valid = 1, waddr = 8, wdata = 0xCAFE, idle ALU -> rf_we = 1 at N+1 with the macro defined, at N+2 without.
REQ-034 Starvation: one load queued, alu_valid held high, STARVE_LIMIT = 3 -> three ALU writes, then alu_ready = 0 and the load is written on the 4th grant, with starve_cnt back at 0.
REQ-035 FIFO full: three loads are offered on consecutive cycles while the ALU saturates the port -> mem_ready = 0 on the 3rd cycle, load_pending = 2, and the loads are later written in order.
REQ-036 Register zero: an ALU write with waddr = 0, wdata = 0xFFFF -> alu_ready = 1, and rf_we = 0 in the next cycle.
REQ-037 Reset mid-stream: reset asserted with load_pending = 2 -> rf_we = 0 and load_pending = 0 immediately, and the discarded loads are never written.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-return writes onto a single register-file write port,
// with a 2-entry load FIFO and bounded ALU priority. Optional macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  load_pending
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [4:0]  fifo_addr_reg [2];
    logic [31:0] fifo_data_reg [2];
    logic        rd_ptr_reg, wr_ptr_reg;
    logic [1:0]  count_reg, count_next;
    logic [2:0]  starve_reg, starve_next;
    logic        rf_we_reg, rf_we_next;
    logic [4:0]  rf_waddr_reg, rf_waddr_next;
    logic [31:0] rf_wdata_reg, rf_wdata_next;

    logic        fifo_nonempty;
    logic        at_limit;
    logic        pop, push, alu_grant, bypass;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    // Handshake readiness depends only on registered state, never on same-cycle pops.
    always_comb begin
        fifo_nonempty = (count_reg != 2'd0);
        at_limit      = (starve_reg == LIMIT);
        alu_ready     = !(fifo_nonempty && at_limit);
        mem_ready     = (count_reg != 2'd2);
        pop           = fifo_nonempty && (at_limit || !alu_valid);
        alu_grant     = alu_valid && !pop;
`ifdef WB_BYPASS_EN
        bypass        = !fifo_nonempty && !alu_valid && mem_valid;
`else
        bypass        = 1'b0;
`endif
        push          = mem_valid && mem_ready && !bypass;
        head_addr     = fifo_addr_reg[rd_ptr_reg];
        head_data     = fifo_data_reg[rd_ptr_reg];
    end

    // Writes to register zero still consume the slot but never assert the enable.
    always_comb begin
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (pop) begin
            rf_we_next    = (head_addr != 5'd0);
            rf_waddr_next = head_addr;
            rf_wdata_next = head_data;
        end else if (alu_grant) begin
            rf_we_next    = (alu_waddr != 5'd0);
            rf_waddr_next = alu_waddr;
            rf_wdata_next = alu_wdata;
        end else if (bypass) begin
            rf_we_next    = (mem_waddr != 5'd0);
            rf_waddr_next = mem_waddr;
            rf_wdata_next = mem_wdata;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (pop || !fifo_nonempty) begin
            starve_next = 3'd0;
        end else if (alu_grant && !at_limit) begin
            starve_next = starve_reg + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            starve_reg   <= 3'd0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 5'd0;
            rf_wdata_reg <= 32'd0;
        end else begin
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            if (push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            count_reg    <= count_next;
            starve_reg   <= starve_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    // Entry storage carries no reset; occupancy and pointers alone define validity.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_addr_reg[gi] <= mem_waddr;
                    fifo_data_reg[gi] <= mem_wdata;
                end
            end
        end
    endgenerate

    assign rf_we        = rf_we_reg;
    assign rf_waddr     = rf_waddr_reg;
    assign rf_wdata     = rf_wdata_reg;
    assign load_pending = count_reg;

endmodule
